// File: rtl/led_matrix_controller_pkg.sv
// rtl/led_matrix_controller_pkg.sv - shared constants and types for the LED matrix controller
// Purpose: panel geometry, FSM state encoding and pixel layout used by every
//          file of the controller.
// Ports:   none (package).
package led_pkg;

  localparam int COLS  = 64;
  localparam int ROWS  = 32;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    SHIFT   = 2'd0,
    LATCH   = 2'd1,
    DISPLAY = 2'd2
  } state_t;

  // Panel pin order on the connector is {spare, B, G, R}.
  typedef struct packed {
    logic spare;
    logic b;
    logic g;
    logic r;
  } pixel_t;

endpackage

// File: rtl/led_matrix_controller_if.sv
// rtl/led_matrix_controller_if.sv - HUB75 panel connector signal bundle
// Purpose: groups every signal wired to the panel connector.
// Ports (master drives, slave observes):
//   col_addr    column currently presented on dout_a/dout_b
//   row_addr    row pair being displayed (top r, bottom r+32)
//   oe          output enable, active-low (1 = blank)
//   latch       latch strobe, active-high, one cycle
//   display_clk shift clock, panel samples dout on its rising edge
//   dout_a      top-half pixel {0,B,G,R}
//   dout_b      bottom-half pixel {0,B,G,R}
interface led_matrix_controller_if;
  import led_pkg::*;

  logic [COL_W-1:0] col_addr;
  logic [ROW_W-1:0] row_addr;
  logic             oe;
  logic             latch;
  logic             display_clk;
  logic [3:0]       dout_a;
  logic [3:0]       dout_b;

  modport master (
    output col_addr, row_addr, oe, latch, display_clk, dout_a, dout_b
  );

  modport slave (
    input col_addr, row_addr, oe, latch, display_clk, dout_a, dout_b
  );

endinterface

// File: rtl/led_matrix_controller_pattern_gen.sv
// rtl/led_matrix_controller_pattern_gen.sv - combinational test-pattern source
// Purpose: maps a scan row and column to the pixel pair for both panel halves.
//   R = column/row parity checkerboard, G = right half of the panel,
//   B = bottom half of the panel, spare = 0.
// Ports:
//   row_i    scan row r (top panel row r, bottom panel row r+32)
//   col_i    column x
//   pix_a_o  top-half pixel
//   pix_b_o  bottom-half pixel
module led_pattern_gen
  import led_pkg::*;
(
  input  logic [ROW_W-1:0] row_i,
  input  logic [COL_W-1:0] col_i,
  output pixel_t           pix_a_o,
  output pixel_t           pix_b_o
);

  // The bottom row is r+32, so it shares bit 0 with the top row and always
  // has bit 5 set; only the blue channel differs between halves.
  always_comb begin
    pix_a_o       = '0;
    pix_a_o.r     = col_i[0] ^ row_i[0];
    pix_a_o.g     = col_i[COL_W-1];
    pix_a_o.b     = 1'b0;
    pix_a_o.spare = 1'b0;

    pix_b_o       = '0;
    pix_b_o.r     = col_i[0] ^ row_i[0];
    pix_b_o.g     = col_i[COL_W-1];
    pix_b_o.b     = 1'b1;
    pix_b_o.spare = 1'b0;
  end

endmodule

// File: rtl/led_matrix_controller.sv
// rtl/led_matrix_controller.sv - HUB75 64x64 panel scan controller top
// Purpose: scans a 1/32 HUB75 panel: shifts one column pair per two clocks,
//          latches the row, then enables the LEDs for ON_CYCLES clocks.
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   panel  connector bundle (master modport), all outputs registered
module led_matrix_controller
  import led_pkg::*;
#(
  parameter int ON_CYCLES = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  led_matrix_controller_if.master panel
);

  localparam int ON_W = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
  localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(ON_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  localparam logic [1:0] S_SHIFT   = SHIFT;
  localparam logic [1:0] S_LATCH   = LATCH;
  localparam logic [1:0] S_DISPLAY = DISPLAY;

  logic [1:0]       state_q,  state_d;
  logic [COL_W-1:0] col_q,    col_d;
  logic             phase_q,  phase_d;
  logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
  logic [ROW_W-1:0] row_q,    row_d;

  logic [COL_W-1:0] col_addr_q;
  logic [ROW_W-1:0] row_addr_q;
  logic             oe_q;
  logic             latch_q;
  logic             dclk_q;
  logic [3:0]       dout_a_q;
  logic [3:0]       dout_b_q;

  pixel_t pix_a;
  pixel_t pix_b;

  // Fed with next-state row/column so the registered pixel lands in the same
  // cycle as the registered col_addr it belongs to.
  led_pattern_gen u_pattern (
    .row_i   (row_d),
    .col_i   (col_d),
    .pix_a_o (pix_a),
    .pix_b_o (pix_b)
  );

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    phase_d  = phase_q;
    on_cnt_d = on_cnt_q;
    row_d    = row_q;
    case (state_q)
      S_SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (col_q == COL_LAST) begin
            state_d = S_LATCH;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_LATCH: begin
        state_d  = S_DISPLAY;
        on_cnt_d = '0;
      end
      S_DISPLAY: begin
        if (on_cnt_q == ON_LAST) begin
          state_d = S_SHIFT;
          col_d   = '0;
          phase_d = 1'b0;
          row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          on_cnt_d = on_cnt_q + ON_W'(1);
        end
      end
      default: begin
        state_d = S_SHIFT;
        col_d   = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_SHIFT;
      col_q      <= '0;
      phase_q    <= 1'b0;
      on_cnt_q   <= '0;
      row_q      <= '0;
      col_addr_q <= '0;
      row_addr_q <= '0;
      oe_q       <= 1'b1;
      latch_q    <= 1'b0;
      dclk_q     <= 1'b0;
      dout_a_q   <= '0;
      dout_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      phase_q  <= phase_d;
      on_cnt_q <= on_cnt_d;
      row_q    <= row_d;

      // Outputs are decoded from the next state so they change together with it.
      oe_q    <= (state_d != S_DISPLAY);
      latch_q <= (state_d == S_LATCH);
      dclk_q  <= (state_d == S_SHIFT) && phase_d;
      if (state_d == S_SHIFT) begin
        col_addr_q <= col_d;
        dout_a_q   <= pix_a;
        dout_b_q   <= pix_b;
      end
      // Row address moves only while the panel is blanked for the latch.
      if (state_d == S_LATCH) begin
        row_addr_q <= row_q;
      end
    end
  end

  assign panel.col_addr    = col_addr_q;
  assign panel.row_addr    = row_addr_q;
  assign panel.oe          = oe_q;
  assign panel.latch       = latch_q;
  assign panel.display_clk = dclk_q;
  assign panel.dout_a      = dout_a_q;
  assign panel.dout_b      = dout_b_q;

endmodule

// File: tb/tb_led_matrix_controller.sv
// tb/tb_led_matrix_controller.sv - self-checking bench for led_matrix_controller
module tb_led_matrix_controller;

  typedef struct packed {
    logic [5:0] col;
    logic [3:0] a;
    logic [3:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  exp_t sb[$];
  int   rows_q[$];

  led_matrix_controller_if panel_if ();

  led_matrix_controller #(.ON_CYCLES(128)) dut (
    .clk   (clk),
    .rst   (rst),
    .panel (panel_if)
  );

  always #5 clk = ~clk;

  // Panel row y, column x: R checkerboard, G right half, B bottom half.
  function automatic logic [3:0] model_px(int y, int x);
    logic [3:0] p;
    p    = 4'b0000;
    p[0] = ((x + y) % 2) == 1;
    p[1] = (x >= 32);
    p[2] = (y >= 32);
    return p;
  endfunction

  // Continuous invariants while running.
  logic       prev_oe  = 1'b1;
  logic [4:0] prev_row = 5'd0;
  always @(negedge clk) begin
    if (mon_en && rst) begin
      tests++;
      if (panel_if.latch && !panel_if.oe) begin
        fails++;
        $display("FAIL inv_latch_oe latch=%b oe=%b (must not overlap)", panel_if.latch, panel_if.oe);
      end
      tests++;
      if (panel_if.dout_a[3] !== 1'b0 || panel_if.dout_b[3] !== 1'b0) begin
        fails++;
        $display("FAIL inv_dout_bit3 dout_a=%b dout_b=%b expected bit3=0", panel_if.dout_a, panel_if.dout_b);
      end
      if (!prev_oe && !panel_if.oe) begin
        tests++;
        if (panel_if.row_addr !== prev_row) begin
          fails++;
          $display("FAIL inv_row_stable row_addr=%0d expected %0d while oe=0", panel_if.row_addr, prev_row);
        end
      end
    end
    prev_oe  = panel_if.oe;
    prev_row = panel_if.row_addr;
  end

  task automatic test_reset();
    logic [21:0] obs;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    obs = {panel_if.oe, panel_if.latch, panel_if.display_clk, panel_if.row_addr,
           panel_if.col_addr, panel_if.dout_a, panel_if.dout_b};
    tests++;
    if (obs !== {1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 4'd0, 4'd0}) begin
      fails++;
      $display("FAIL reset_hold {oe,latch,dclk,row,col,a,b}=%b expected oe=1 rest 0", obs);
    end
  endtask

  task automatic test_first_row();
    logic prev_dclk = 1'b0;
    exp_t e;
    exp_t obs;
    for (int c = 0; c < 64; c++) begin
      e.col = 6'(c);
      e.a   = model_px(0, c);
      e.b   = model_px(32, c);
      sb.push_back(e);
    end
    rst    = 1'b1;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 400 && sb.size() > 0; cyc++) begin
      @(negedge clk);
      if (panel_if.display_clk && !prev_dclk) begin
        e   = sb.pop_front();
        obs = {panel_if.col_addr, panel_if.dout_a, panel_if.dout_b};
        tests++;
        if (obs !== e) begin
          fails++;
          $display("FAIL first_row_edge col/a/b=%0d/%b/%b expected %0d/%b/%b",
                   obs.col, obs.a, obs.b, e.col, e.a, e.b);
        end
      end
      prev_dclk = panel_if.display_clk;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL first_row_timeout remaining edges=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_latch();
    logic [7:0] obs;
    @(negedge clk);
    obs = {panel_if.latch, panel_if.oe, panel_if.display_clk, panel_if.row_addr};
    tests++;
    if (obs !== {1'b1, 1'b1, 1'b0, 5'd0}) begin
      fails++;
      $display("FAIL latch_pulse {latch,oe,dclk,row}=%b expected 11000000", obs);
    end
  endtask

  task automatic test_on_time();
    int   on_cnt = 0;
    bit   bad    = 1'b0;
    logic [15:0] obs;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (panel_if.oe) break;
      on_cnt++;
      if (panel_if.display_clk || panel_if.latch) bad = 1'b1;
    end
    tests++;
    if (on_cnt !== 128) begin
      fails++;
      $display("FAIL on_time oe_low_cycles=%0d expected 128", on_cnt);
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL on_time_quiet dclk/latch active=1 expected 0 while oe=0");
    end
    obs = {panel_if.display_clk, panel_if.latch, panel_if.col_addr, panel_if.dout_a, panel_if.dout_b};
    tests++;
    if (obs !== {1'b0, 1'b0, 6'd0, model_px(1, 0), model_px(33, 0)}) begin
      fails++;
      $display("FAIL row1_start {dclk,latch,col,a,b}=%b expected %b", obs,
               {1'b0, 1'b0, 6'd0, model_px(1, 0), model_px(33, 0)});
    end
  endtask

  task automatic test_wrap();
    logic prev_dclk = 1'b0;
    int   nlat = 0;
    int   prev_lat = -1;
    int   er;
    logic [7:0] obs;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < 32; r++) rows_q.push_back(r);
    rows_q.push_back(0);
    for (int cyc = 0; cyc < 33 * 257 + 600 && rows_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (panel_if.display_clk && !prev_dclk) begin
        obs = {panel_if.dout_a, panel_if.dout_b};
        tests++;
        if (obs !== {model_px(nlat % 32, panel_if.col_addr), model_px(nlat % 32 + 32, panel_if.col_addr)}) begin
          fails++;
          $display("FAIL wrap_pixel row=%0d col=%0d a/b=%b expected %b", nlat % 32, panel_if.col_addr, obs,
                   {model_px(nlat % 32, panel_if.col_addr), model_px(nlat % 32 + 32, panel_if.col_addr)});
        end
      end
      prev_dclk = panel_if.display_clk;
      if (panel_if.latch) begin
        er = rows_q.pop_front();
        tests++;
        if (panel_if.row_addr !== 5'(er)) begin
          fails++;
          $display("FAIL wrap_row latch#%0d row_addr=%0d expected %0d", nlat, panel_if.row_addr, er);
        end
        if (prev_lat >= 0) begin
          tests++;
          if (cyc - prev_lat !== 257) begin
            fails++;
            $display("FAIL wrap_spacing latch#%0d spacing=%0d expected 257", nlat, cyc - prev_lat);
          end
        end
        prev_lat = cyc;
        nlat++;
      end
    end
    tests++;
    if (rows_q.size() != 0) begin
      fails++;
      $display("FAIL wrap_timeout latches=%0d expected 33", nlat);
      rows_q.delete();
    end
  endtask

  task automatic test_reset_mid_display();
    logic [21:0] obs;
    bit   seen = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!panel_if.oe) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL mid_display_wait oe=%b expected 0 within 400 cycles", panel_if.oe);
    end
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    obs = {panel_if.oe, panel_if.latch, panel_if.display_clk, panel_if.row_addr,
           panel_if.col_addr, panel_if.dout_a, panel_if.dout_b};
    tests++;
    if (obs !== {1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 4'd0, 4'd0}) begin
      fails++;
      $display("FAIL reset_async {oe,latch,dclk,row,col,a,b}=%b expected oe=1 rest 0", obs);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    obs = {panel_if.oe, panel_if.latch, panel_if.display_clk, panel_if.row_addr,
           panel_if.col_addr, panel_if.dout_a, panel_if.dout_b};
    tests++;
    if (obs !== {1'b1, 1'b0, 1'b1, 5'd0, 6'd0, model_px(0, 0), model_px(32, 0)}) begin
      fails++;
      $display("FAIL restart_first_edge {oe,latch,dclk,row,col,a,b}=%b expected %b", obs,
               {1'b1, 1'b0, 1'b1, 5'd0, 6'd0, model_px(0, 0), model_px(32, 0)});
    end
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_latch();
    test_on_time();
    test_wrap();
    test_reset_mid_display();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
